// File: rtl/e1_tune_pkg.sv
// rtl/e1_tune_pkg.sv - shared state encoding and default widths for the E1 tune loop
package e1_tune_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ARM   = 3'd1;
    localparam logic [2:0] ST_MEAS  = 3'd2;
    localparam logic [2:0] ST_CALC  = 3'd3;
    localparam logic [2:0] ST_APPLY = 3'd4;

    localparam int E1_WIN_LOG = 3;
    localparam int E1_CW      = 16;
    localparam int E1_OW      = 12;
    localparam int E1_IW      = 24;

endpackage

// File: rtl/e1_tune_pi.sv
// rtl/e1_tune_pi.sv - saturating PI filter: error/integrator registers and clamped tune sum
module e1_tune_pi
    import e1_tune_pkg::*;
#(
    parameter int CW = E1_CW,
    parameter int OW = E1_OW,
    parameter int IW = E1_IW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 calc,
    input  logic [CW-1:0]        target,
    input  logic [CW-1:0]        cnt_snap,
    input  logic [OW-1:0]        init,
    input  logic [3:0]           kp_sh,
    input  logic [3:0]           ki_sh,
    output logic signed [CW:0]   err,
    output logic [OW-1:0]        sum,
    output logic                 sum_clamp
);

    localparam logic signed [IW-1:0] INT_MAX = {1'b0, {(IW-1){1'b1}}};
    localparam logic signed [IW-1:0] INT_MIN = {1'b1, {(IW-1){1'b0}}};

    logic signed [IW-1:0] integ;
    logic signed [IW-1:0] integ_nx;
    logic signed [CW:0]   err_c;
    logic signed [IW:0]   isum;
    logic signed [CW:0]   err_sh;
    logic signed [IW-1:0] int_sh;
    logic signed [IW+1:0] total;

    assign err_c = $signed({1'b0, target}) - $signed({1'b0, cnt_snap});
    assign isum  = $signed({{(IW-CW){err_c[CW]}}, err_c}) + $signed({integ[IW-1], integ});

    // One guard bit: a disagreement between the top two bits means the add overflowed.
    assign integ_nx = (isum[IW] != isum[IW-1]) ? (isum[IW] ? INT_MIN : INT_MAX)
                                               : isum[IW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            integ <= '0;
            err   <= '0;
        end else if (clr) begin
            integ <= '0;
        end else if (calc) begin
            err   <= err_c;
            integ <= integ_nx;
        end
    end

    assign err_sh = err >>> kp_sh;
    assign int_sh = integ >>> ki_sh;
    assign total  = $signed({{(IW+2-OW){1'b0}}, init})
                  + $signed({{(IW+1-CW){err_sh[CW]}}, err_sh})
                  + $signed({{2{int_sh[IW-1]}}, int_sh});

    always_comb begin
        sum       = total[OW-1:0];
        sum_clamp = 1'b0;
        if (total[IW+1]) begin
            sum       = '0;
            sum_clamp = 1'b1;
        end else if (|total[IW:OW]) begin
            sum       = '1;
            sum_clamp = 1'b1;
        end
    end

endmodule

// File: rtl/e1_clk_tune_loop.sv
// rtl/e1_clk_tune_loop.sv - E1 oscillator frequency-lock loop: window counting, FSM and status
module e1_clk_tune_loop
    import e1_tune_pkg::*;
#(
    parameter int WIN_LOG = E1_WIN_LOG,
    parameter int CW      = E1_CW,
    parameter int OW      = E1_OW,
    parameter int IW      = E1_IW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_en,
    input  logic [CW-1:0]       cfg_target,
    input  logic [OW-1:0]       cfg_init,
    input  logic [3:0]          cfg_kp_sh,
    input  logic [3:0]          cfg_ki_sh,
    input  logic [7:0]          cfg_lock_thr,
    input  logic                tick_e1,
    input  logic                tick_usb_sof,
    output logic [OW-1:0]       out_val,
    output logic                out_stb,
    output logic signed [CW:0]  stat_err,
    output logic                stat_lock,
    output logic                stat_sat
);

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic [1:0]          rst_sync;
    logic                rst_i_n;
    logic [2:0]          state;
    logic [CW-1:0]       tick_cnt;
    logic [CW-1:0]       cnt_snap;
    logic [WIN_LOG-1:0]  sof_cnt;
    logic                pend;
    logic                init_sel;
    logic                en_d;
    logic [OW-1:0]       out_q;
    logic [1:0]          lock_cnt;
    logic                counting;
    logic                win_close;
    logic                pi_calc;
    logic                pi_clamp;
    logic                err_good;
    logic signed [CW:0]  pi_err;
    logic [CW:0]         err_abs;
    logic [OW-1:0]       pi_sum;

    // Reset asserts immediately but is released only after two clean clk edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_i_n = rst_sync[1];

    assign counting  = (state == ST_MEAS) || (state == ST_CALC) || (state == ST_APPLY);
    assign win_close = counting && tick_usb_sof && (sof_cnt == '1);
    assign pi_calc   = cfg_en && (state == ST_CALC);
    assign err_abs   = pi_err[CW] ? $unsigned(-pi_err) : $unsigned(pi_err);
    assign err_good  = err_abs <= {{(CW-7){1'b0}}, cfg_lock_thr};

    // Until the first update after enabling, the output follows cfg_init live.
    assign out_val = init_sel ? cfg_init : out_q;

    e1_tune_pi #(
        .CW (CW),
        .OW (OW),
        .IW (IW)
    ) u_pi (
        .clk       (clk),
        .rst_n     (rst_i_n),
        .clr       (!cfg_en),
        .calc      (pi_calc),
        .target    (cfg_target),
        .cnt_snap  (cnt_snap),
        .init      (cfg_init),
        .kp_sh     (cfg_kp_sh),
        .ki_sh     (cfg_ki_sh),
        .err       (pi_err),
        .sum       (pi_sum),
        .sum_clamp (pi_clamp)
    );

    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n) begin
            state     <= ST_IDLE;
            tick_cnt  <= '0;
            cnt_snap  <= '0;
            sof_cnt   <= '0;
            pend      <= 1'b0;
            init_sel  <= 1'b1;
            en_d      <= 1'b0;
            out_q     <= '0;
            out_stb   <= 1'b0;
            stat_err  <= '0;
            lock_cnt  <= '0;
            stat_lock <= 1'b0;
            stat_sat  <= 1'b0;
        end else begin
            en_d    <= cfg_en;
            out_stb <= 1'b0;
            if (!cfg_en) begin
                state     <= ST_IDLE;
                lock_cnt  <= '0;
                stat_lock <= 1'b0;
                init_sel  <= 1'b1;
                pend      <= 1'b0;
            end else begin
                if (!en_d) stat_sat <= 1'b0;

                // Counting runs through CALC/APPLY so no tick is lost between windows.
                if (counting) begin
                    if (tick_usb_sof) sof_cnt <= sof_cnt + 1'b1;
                    if (win_close) begin
                        cnt_snap <= tick_cnt;
                        tick_cnt <= {{(CW-1){1'b0}}, tick_e1};
                    end else if (tick_e1) begin
                        if (tick_cnt == CNT_MAX) stat_sat <= 1'b1;
                        else                     tick_cnt <= tick_cnt + 1'b1;
                    end
                end

                case (state)
                    ST_IDLE: state <= ST_ARM;
                    ST_ARM: begin
                        if (tick_usb_sof) begin
                            tick_cnt <= '0;
                            sof_cnt  <= '0;
                            state    <= ST_MEAS;
                        end
                    end
                    ST_MEAS: begin
                        if (win_close) state <= ST_CALC;
                    end
                    ST_CALC: begin
                        state <= ST_APPLY;
                        if (win_close) pend <= 1'b1;
                    end
                    ST_APPLY: begin
                        out_q    <= pi_sum;
                        init_sel <= 1'b0;
                        out_stb  <= 1'b1;
                        stat_err <= pi_err;
                        if (pi_clamp) stat_sat <= 1'b1;
                        if (err_good) begin
                            if (lock_cnt == 2'd3) stat_lock <= 1'b1;
                            else                  lock_cnt  <= lock_cnt + 1'b1;
                        end else begin
                            lock_cnt  <= '0;
                            stat_lock <= 1'b0;
                        end
                        pend  <= 1'b0;
                        state <= (pend || win_close) ? ST_CALC : ST_MEAS;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_e1_clk_tune_loop.sv
// tb/tb_e1_clk_tune_loop.sv - randomized self-checking bench with windowed PI reference model
module tb_e1_clk_tune_loop;

    localparam int WIN_LOG = 3;
    localparam int CW      = 12;
    localparam int OW      = 12;
    localparam int IW      = 16;
    localparam int NSOF    = 1 << WIN_LOG;
    localparam int CNT_MAX = (1 << CW) - 1;
    localparam int OUT_MAX = (1 << OW) - 1;
    localparam int I_MAX   = (1 << (IW - 1)) - 1;
    localparam int I_MIN   = -(1 << (IW - 1));

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               cfg_en = 1'b0;
    logic [CW-1:0]      cfg_target = '0;
    logic [OW-1:0]      cfg_init = 12'h800;
    logic [3:0]         cfg_kp_sh = '0;
    logic [3:0]         cfg_ki_sh = '0;
    logic [7:0]         cfg_lock_thr = '0;
    logic               tick_e1 = 1'b0;
    logic               tick_usb_sof = 1'b0;
    logic [OW-1:0]      out_val;
    logic               out_stb;
    logic signed [CW:0] stat_err;
    logic               stat_lock;
    logic               stat_sat;

    e1_clk_tune_loop #(
        .WIN_LOG (WIN_LOG),
        .CW      (CW),
        .OW      (OW),
        .IW      (IW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_en       (cfg_en),
        .cfg_target   (cfg_target),
        .cfg_init     (cfg_init),
        .cfg_kp_sh    (cfg_kp_sh),
        .cfg_ki_sh    (cfg_ki_sh),
        .cfg_lock_thr (cfg_lock_thr),
        .tick_e1      (tick_e1),
        .tick_usb_sof (tick_usb_sof),
        .out_val      (out_val),
        .out_stb      (out_stb),
        .stat_err     (stat_err),
        .stat_lock    (stat_lock),
        .stat_sat     (stat_sat)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_n = 0;
    int n_stb = 0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic check_val(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    typedef struct {
        int  out;
        int  err;
        bit  lock;
        bit  sat;
        int  cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   m_integ;
    int   m_run;
    bit   m_sat;

    // Reference: one full window of ticks in, one expected update out.
    task automatic model_close(input int cnt, input int c);
        int   c2;
        int   err;
        int   s;
        exp_t e;
        c2 = cnt;
        if (cnt > CNT_MAX) begin
            c2    = CNT_MAX;
            m_sat = 1'b1;
        end
        err     = int'(cfg_target) - c2;
        m_integ = m_integ + err;
        if (m_integ > I_MAX) m_integ = I_MAX;
        if (m_integ < I_MIN) m_integ = I_MIN;
        s = int'(cfg_init) + (err >>> int'(cfg_kp_sh)) + (m_integ >>> int'(cfg_ki_sh));
        if (s < 0) begin
            s     = 0;
            m_sat = 1'b1;
        end else if (s > OUT_MAX) begin
            s     = OUT_MAX;
            m_sat = 1'b1;
        end
        m_run  = (((err < 0) ? -err : err) <= int'(cfg_lock_thr)) ? m_run + 1 : 0;
        e.out  = s;
        e.err  = err;
        e.lock = (m_run >= 4);
        e.sat  = m_sat;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (out_stb) begin
            n_stb <= n_stb + 1;
            if (exp_q.size() == 0) begin
                check_val("stb_unexpected", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check_val("out_val", out_val, mon_e.out);
                check_val("stat_err", stat_err, mon_e.err);
                check_val("stat_lock", stat_lock, mon_e.lock);
                check_val("stat_sat", stat_sat, mon_e.sat);
                check_val("stb_latency", cyc_n - mon_e.cyc, 3);
            end
        end
    end

    task automatic clk_cyc(input bit sof, input bit tick);
        tick_usb_sof = sof;
        tick_e1      = tick;
        @(posedge clk);
        #1;
        tick_usb_sof = 1'b0;
        tick_e1      = 1'b0;
    endtask

    task automatic send_interval(input int n, input int len, input bit tick_on_sof);
        int rem;
        bit t;
        rem = n;
        clk_cyc(1'b1, tick_on_sof);
        for (int k = 1; k < len; k++) begin
            t = (rem > 0) && (($urandom_range(0, 1) == 1) || (rem >= len - k));
            if (t) rem--;
            clk_cyc(1'b0, t);
        end
    endtask

    task automatic run_windows(input int nw, input int tpi, input int jit, input bit coinc);
        int cnt;
        int n;
        int base;
        bit ts;
        cnt  = 0;
        base = n_stb;
        for (int s = 0; s <= nw * NSOF; s++) begin
            ts = coinc && (s == NSOF) && (nw > 1);
            if (s > 0 && (s % NSOF) == 0) begin
                model_close(cnt, cyc_n);
                cnt = ts ? 1 : 0;
            end
            if (s == nw * NSOF) begin
                send_interval(0, 6, 1'b0);
            end else begin
                n = tpi + int'($urandom_range(0, 2 * jit)) - jit;
                if (n < 0) n = 0;
                if (coinc && nw > 1 && s == NSOF - 1 && n > 0) n--;
                cnt += n;
                send_interval(n, n + 4 + int'($urandom_range(0, 3)), ts);
            end
        end
        check_val("stb_count", n_stb - base, nw);
        check_val("queue_drained", exp_q.size(), 0);
    endtask

    task automatic start_scn(input int t, input int ini, input int kp, input int ki, input int th);
        cfg_en = 1'b0;
        clk_cyc(1'b0, 1'b0);
        check_val("dis_out_val", out_val, cfg_init);
        check_val("dis_lock", stat_lock, 0);
        cfg_target   = CW'(t);
        cfg_init     = OW'(ini);
        cfg_kp_sh    = 4'(kp);
        cfg_ki_sh    = 4'(ki);
        cfg_lock_thr = 8'(th);
        clk_cyc(1'b0, 1'b0);
        check_val("idle_tracks_init", out_val, ini);
        cfg_en = 1'b1;
        clk_cyc(1'b0, 1'b0);
        clk_cyc(1'b0, 1'b0);
        check_val("en_sat_clear", stat_sat, 0);
        m_integ = 0;
        m_run   = 0;
        m_sat   = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        #1;
        repeat (3) clk_cyc(1'b0, 1'b0);
        check_val("rst_out_val", out_val, 12'h800);
        check_val("rst_out_stb", out_stb, 0);
        check_val("rst_stat_err", stat_err, 0);
        check_val("rst_stat_lock", stat_lock, 0);
        check_val("rst_stat_sat", stat_sat, 0);
        rst_n = 1'b1;
        repeat (3) clk_cyc(1'b0, 1'b0);

        // Zero error: steady output, lock on the fourth good window.
        start_scn(256, 12'h800, 4, 8, 16);
        run_windows(5, 32, 0, 1'b0);
        check_val("lock_held", stat_lock, 1);

        // Constant +64 error: proportional step plus growing integral.
        start_scn(256, 12'h800, 4, 8, 16);
        run_windows(4, 24, 0, 1'b0);

        // Large positive error: output clamps high.
        start_scn(4000, 12'hF00, 0, 15, 4);
        run_windows(3, 1, 0, 1'b0);

        // Integrator reaches its positive limit and holds.
        start_scn(4000, 0, 15, 4, 0);
        run_windows(10, 0, 0, 1'b0);

        // Tick counter saturation drives the output to zero.
        start_scn(100, 12'h800, 0, 15, 4);
        run_windows(1, 600, 0, 1'b0);

        // Async reset in the middle of a window.
        for (int i = 0; i < 3; i++) send_interval(20, 30, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_out_val", out_val, cfg_init);
        check_val("arst_out_stb", out_stb, 0);
        check_val("arst_stat_err", stat_err, 0);
        check_val("arst_stat_lock", stat_lock, 0);
        check_val("arst_stat_sat", stat_sat, 0);
        clk_cyc(1'b0, 1'b0);
        clk_cyc(1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (3) clk_cyc(1'b0, 1'b0);

        // Tick moved onto the closing SOF lands in the next window.
        start_scn(256, 12'h800, 0, 15, 4);
        run_windows(2, 32, 0, 1'b1);

        // Random gains and jitter; each ends with a disable mid-window.
        for (int r = 0; r < 4; r++) begin
            start_scn(int'($urandom_range(200, 300)), int'($urandom_range(12'h400, 12'hC00)),
                      int'($urandom_range(0, 6)), int'($urandom_range(0, 8)),
                      int'($urandom_range(0, 20)));
            run_windows(5, 32, 3, 1'b0);
            for (int i = 0; i < 3; i++) send_interval(30, 40, 1'b0);
        end
        start_scn(256, 12'h800, 4, 8, 16);
        repeat (4) clk_cyc(1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
